// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder and the core-side load/store adapter.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Major opcodes the core-side adapter decodes into read/write requests.
    localparam logic [5:0] OPC_LW = 6'b100011;
    localparam logic [5:0] OPC_SW = 6'b101011;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    function automatic int index_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port synchronous word RAM with write enable and a registered, read-first output.
module word_ram
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Contents are deliberately left uninitialised so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port: one request at a time,
// a programmable number of wait states, and a response held until the core takes it.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = index_width(DEPTH);

    state_t state, state_next;

    logic [CNT_W-1:0]  count;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic              err_q;
    logic              load_q;

    logic              accept;
    logic              commit;
    logic              cur_write;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic              cur_err;
    logic [IDX_W-1:0]  cur_idx;
    logic [31:0]       ram_rdata;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = (state == IDLE) && req_valid;

    // With zero wait states the commit edge is the accept edge, so the RAM must
    // see the live request; otherwise it sees the copy latched at acceptance.
    always_comb begin
        cur_write = lat_write;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        if (state == IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end
    end

    assign cur_err = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (IDX_W + 2)) != '0);
    assign cur_idx = cur_addr[IDX_W+1:2];

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (count == CNT_W'(1)) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            err_q     <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                count     <= CNT_W'(WAIT_CYCLES);
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end else if (state == WAIT) begin
                count <= count - CNT_W'(1);
            end
            // load_q marks a good load, so the RAM output is shown only then.
            if (commit) begin
                err_q  <= cur_err;
                load_q <= !cur_write && !cur_err;
            end else if ((state == RESP) && rsp_ready) begin
                err_q  <= 1'b0;
                load_q <= 1'b0;
            end
        end
    end

    word_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .en    (commit),
        .we    (commit && cur_write && !cur_err),
        .addr  (cur_idx),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    assign rsp_rdata = load_q ? ram_rdata : 32'h0;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: randomized traffic against a word-array model,
// plus directed reset, backpressure and zero-wait-state checks.
module tb_data_mem_responder;

    localparam int DEPTH  = 256;
    localparam int W      = 2;
    localparam int DEPTH0 = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic        req_valid_z, req_ready_z, req_write_z, rsp_valid_z, rsp_ready_z, rsp_err_z;
    logic [31:0] req_addr_z, req_wdata_z, rsp_rdata_z;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_mode = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_data;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic        have_cur = 1'b0;
    logic        prev_hs  = 1'b0;
    logic [31:0] held_rdata;
    logic        held_err;
    logic [31:0] model  [int];
    logic [31:0] model0 [int];

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH(DEPTH0), .WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid_z), .req_ready(req_ready_z),
        .req_write(req_write_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected response from the access rules alone: word array, alignment and range.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit scored);
        exp_t e;
        int   waited = 0;
        bit   ok = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        while (!ok && waited < 100) begin
            @(negedge clk);
            if (req_ready) ok = 1; else waited++;
        end
        if (!ok) begin
            checkOutput("accept_timeout", 32'(req_ready), 32'(1));
        end else if (scored) begin
            e.err      = (addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH));
            e.acc      = cyc;
            e.chk_data = 1'b1;
            e.rdata    = 32'h0;
            if (!e.err) begin
                if (wr) model[int'(addr >> 2)] = wdata;
                else if (model.exists(int'(addr >> 2))) e.rdata = model[int'(addr >> 2)];
                else e.chk_data = 1'b0;
            end
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((exp_q.size() != 0 || have_cur) && n < 300) begin
            @(negedge clk); n++;
        end
        if (n >= 300) checkOutput("drain_timeout", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic waitRsp();
        int n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk); n++;
        end
        if (n >= 50) checkOutput("rsp_timeout", 32'(rsp_valid), 32'(1));
    endtask

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 2) != 0);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops one expectation per response and watches it stay put until taken.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            have_cur = 1'b0;
            prev_hs  = 1'b0;
        end else begin
            if (prev_hs) begin
                checkOutput("post_hs_rsp_valid", 32'(rsp_valid), 32'(0));
                checkOutput("post_hs_req_ready", 32'(req_ready), 32'(1));
                prev_hs = 1'b0;
            end
            if (rsp_valid) begin
                if (!have_cur) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("[TB] FAIL unexpected_rsp: got rsp_valid=1, expected no response");
                    end else begin
                        cur = exp_q.pop_front();
                        checkOutput("rsp_err", 32'(rsp_err), 32'(cur.err));
                        if (cur.chk_data) checkOutput("rsp_rdata", rsp_rdata, cur.rdata);
                        checkOutput("latency", 32'(cyc - cur.acc), 32'(W + 1));
                    end
                    have_cur   = 1'b1;
                    held_rdata = rsp_rdata;
                    held_err   = rsp_err;
                end else begin
                    checkOutput("stable_rdata", rsp_rdata, held_rdata);
                    checkOutput("stable_err", 32'(rsp_err), 32'(held_err));
                end
                checkOutput("busy_req_ready", 32'(req_ready), 32'(0));
                if (rsp_ready) begin
                    have_cur = 1'b0;
                    prev_hs  = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500000");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] pool [8];
        logic        z_wr   [9];
        logic [31:0] z_addr [9];
        logic [31:0] z_data [9];
        logic [31:0] z_exp_rdata;
        logic        z_exp_err;
        logic [31:0] a;

        pool = '{32'h0, 32'h4, 32'h10, 32'h20, 32'h24, 32'h3FC, 32'h200, 32'h1F0};
        z_wr   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        z_addr = '{32'h0, 32'h4, 32'h3C, 32'h0, 32'h4, 32'h3C, 32'h40, 32'h42, 32'h2};
        z_data = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'h0, 32'h0, 32'h0, 32'h0,
                   32'h12345678, 32'h0};

        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_valid_z = 1'b0; req_write_z = 1'b0; req_addr_z = '0; req_wdata_z = '0;
        rsp_ready_z = 1'b1;

        @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'(1));
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'(0));
        checkOutput("reset_z_req_ready", 32'(req_ready_z), 32'(1));
        checkOutput("reset_z_rsp_valid", 32'(rsp_valid_z), 32'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Store then load the same word.
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 1);
        applyStimulus(1'b0, 32'h10, 32'h0, 1);
        waitDrain();

        // Misaligned and out-of-range accesses; the bad store must not touch word 4.
        applyStimulus(1'b0, 32'h12, 32'h0, 1);
        applyStimulus(1'b0, 32'(4 * DEPTH), 32'h0, 1);
        applyStimulus(1'b1, 32'h12, 32'hBAD0BAD0, 1);
        applyStimulus(1'b0, 32'h10, 32'h0, 1);
        waitDrain();

        // Backpressure on a load for five cycles.
        ready_mode = 2;
        applyStimulus(1'b0, 32'h10, 32'h0, 1);
        waitRsp();
        repeat (5) @(negedge clk);
        ready_mode = 0;
        waitDrain();

        // Randomized traffic over a small address pool.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, pool[i], $urandom, 1);
        ready_mode = 1;
        for (int i = 0; i < 50; i++) begin
            a = pool[$urandom_range(0, 7)];
            case ($urandom_range(0, 9))
                0:       a = a + 32'($urandom_range(1, 3));
                1:       a = a | (($urandom_range(0, 1) == 0) ? 32'h400 : 32'h80000000);
                default: ;
            endcase
            applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        ready_mode = 0;
        waitDrain();

        // Reset while a store waits: the old word survives.
        applyStimulus(1'b1, 32'h20, 32'h11111111, 1);
        waitDrain();
        applyStimulus(1'b1, 32'h20, 32'h99999999, 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_wait_rsp_valid", 32'(rsp_valid), 32'(0));
        checkOutput("rst_wait_req_ready", 32'(req_ready), 32'(1));
        exp_q.delete();
        @(negedge clk); #2 rst = 1'b0;
        applyStimulus(1'b0, 32'h20, 32'h0, 1);
        waitDrain();

        // Reset while a committed store sits in the response stage.
        ready_mode = 2;
        applyStimulus(1'b1, 32'h24, 32'h22222222, 1);
        waitRsp();
        @(posedge clk); #3 rst = 1'b1;
        #1;
        checkOutput("rst_resp_rsp_valid", 32'(rsp_valid), 32'(0));
        checkOutput("rst_resp_req_ready", 32'(req_ready), 32'(1));
        checkOutput("rst_resp_rsp_err", 32'(rsp_err), 32'(0));
        exp_q.delete();
        ready_mode = 0;
        @(negedge clk); #2 rst = 1'b0;
        applyStimulus(1'b0, 32'h24, 32'h0, 1);
        waitDrain();

        // Zero wait states, request held valid: accept and respond on alternate cycles.
        @(posedge clk); #1;
        req_valid_z = 1'b1; req_write_z = z_wr[0]; req_addr_z = z_addr[0]; req_wdata_z = z_data[0];
        z_exp_rdata = 32'h0; z_exp_err = 1'b0;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                checkOutput("z_req_ready", 32'(req_ready_z), 32'(1));
                checkOutput("z_rsp_valid", 32'(rsp_valid_z), 32'(0));
                a = z_addr[k / 2];
                z_exp_err   = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH0));
                z_exp_rdata = 32'h0;
                if (!z_exp_err) begin
                    if (z_wr[k / 2]) model0[int'(a >> 2)] = z_data[k / 2];
                    else z_exp_rdata = model0[int'(a >> 2)];
                end
            end else begin
                checkOutput("z_rsp_valid", 32'(rsp_valid_z), 32'(1));
                checkOutput("z_req_ready", 32'(req_ready_z), 32'(0));
                checkOutput("z_rsp_err", 32'(rsp_err_z), 32'(z_exp_err));
                checkOutput("z_rsp_rdata", rsp_rdata_z, z_exp_rdata);
            end
            @(posedge clk); #1;
            if (k % 2 == 0) begin
                if (k / 2 + 1 < 9) begin
                    req_write_z = z_wr[k / 2 + 1];
                    req_addr_z  = z_addr[k / 2 + 1];
                    req_wdata_z = z_data[k / 2 + 1];
                end else begin
                    req_valid_z = 1'b0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
